// File: rtl/mod_mul.sv
// mod_mul: sequential Blakley modular multiplier, z = (x*y) mod m, scanning x MSB-first one bit per clock.
// Optional build macro MOD_MUL_RANGE_CHECK_EN adds an err output that flags operands >= m.
module mod_mul #(
    parameter int           k    = 192,
    parameter int           logk = 8,
    parameter logic [k-1:0] m    = 192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [k-1:0] x,
    input  logic [k-1:0] y,
    input  logic         start,
    output logic [k-1:0] z,
    output logic         done
`ifdef MOD_MUL_RANGE_CHECK_EN
    ,
    output logic         err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [k+1:0]    M_EXT = {2'b00, m};
    localparam logic [logk-1:0] CNT_TOP = logk'(k - 1);

    // One conditional subtraction; applied twice since 2p + y < 3m for in-range operands.
    function automatic logic [k+1:0] reduce_once(input logic [k+1:0] v);
        return (v >= M_EXT) ? (v - M_EXT) : v;
    endfunction

    state_t          state_q, state_d;
    logic            start_q;
    logic [k-1:0]    xr_q, xr_d, yr_q, yr_d;
    logic [k-1:0]    z_q, z_d;
    logic [k+1:0]    p_q, p_d;
    logic [logk-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            start_rise, accept;
    logic [k+1:0]    t_sum, t_red;

`ifdef MOD_MUL_RANGE_CHECK_EN
    logic err_q, err_d, bad_op;
    assign bad_op = (x >= m) || (y >= m);
    assign err    = err_q;
`endif

    assign start_rise = start & ~start_q;
    assign accept     = start_rise && (state_q != BUSY);

    assign t_sum = (p_q << 1) + (xr_q[cnt_q] ? {2'b00, yr_q} : '0);
    assign t_red = reduce_once(reduce_once(t_sum));

    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        z_d     = z_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
`ifdef MOD_MUL_RANGE_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    xr_d    = x;
                    yr_d    = y;
                    p_d     = '0;
                    cnt_d   = CNT_TOP;
                    done_d  = 1'b0;
                    state_d = BUSY;
`ifdef MOD_MUL_RANGE_CHECK_EN
                    err_d   = 1'b0;
                    if (bad_op) begin
                        state_d = DONE;
                        z_d     = '0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            BUSY: begin
                p_d   = t_red;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    z_d     = t_red[k-1:0];
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            z_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef MOD_MUL_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            start_q <= start;
            z_q     <= z_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef MOD_MUL_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Operand latches carry no control meaning, so they are left out of reset.
    always_ff @(posedge clk) begin
        xr_q <= xr_d;
        yr_q <= yr_d;
    end

    assign z    = z_q;
    assign done = done_q;

endmodule

// File: tb/tb_mod_mul.sv
// Directed + randomized bench for mod_mul; expected results come from wide-integer (x*y) % m arithmetic.
module tb_mod_mul;
    localparam int K = 192;
    localparam logic [K-1:0] M = 192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [K-1:0] x, y, z;
    logic         done;
`ifdef MOD_MUL_RANGE_CHECK_EN
    logic         err;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mod_mul #(.k(K), .logk(8), .m(M)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .start(start), .z(z), .done(done)
`ifdef MOD_MUL_RANGE_CHECK_EN
        , .err(err)
`endif
    );

    function automatic logic [K-1:0] ref_mulmod(input logic [K-1:0] a, input logic [K-1:0] b);
        logic [2*K-1:0] prod;
        logic [2*K-1:0] rem;
        prod = {{K{1'b0}}, a} * {{K{1'b0}}, b};
        rem  = prod % {{K{1'b0}}, M};
        return rem[K-1:0];
    endfunction

    function automatic logic [K-1:0] rand_operand();
        logic [K-1:0] v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (v >= M) v = v - M;
        return v;
    endfunction

    task automatic check(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation; optionally re-pulse start mid-BUSY with scrambled operands.
    task automatic run_op(input string tag, input logic [K-1:0] xa, input logic [K-1:0] ya,
                          input logic [K-1:0] exp, input int pulse_at);
        int cyc;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        x = xa;
        y = ya;
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " done_clear"}, K'(done), '0);
        x = rand_operand();
        y = rand_operand();
        cyc = 0;
        while (cyc < K + 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
            if (pulse_at > 0) begin
                if (cyc == pulse_at) start = 1'b0;
                else if (cyc == pulse_at + 1) start = 1'b1;
                else if (cyc == pulse_at + 2) start = 1'b0;
            end
        end
        check({tag, " latency"}, K'(cyc), K'(K));
        check({tag, " z"}, z, exp);
    endtask

    initial begin
        logic [K-1:0] a, b, prev_z;
        int bad;

        rst = 1'b1;
        start = 1'b0;
        x = '0;
        y = '0;
        @(posedge clk);
        #1;
        check("reset z", z, '0);
        check("reset done", K'(done), '0);
        rst = 1'b0;

        run_op("small", K'(8'hF7), K'(8'h0A), K'(12'h9A6), 0);

        a = '0; a[64] = 1'b1; a[0] = 1'b1;
        b = '0; b[128] = 1'b1; b[65] = 1'b1; b[0] = 1'b1;
        run_op("sq_2p64p1", a, a, b, 0);

        b = a * K'(11);
        prev_z = '0; prev_z[131:128] = 4'hB; prev_z[71:64] = 8'h16; prev_z[3:0] = 4'hB;
        run_op("mul_11", a, b, prev_z, 0);

        b = '0; b[191] = 1'b1;
        run_op("wrap_2p192", b, K'(2), a, 0);

        run_op("m_minus_1_sq", M - 1'b1, M - 1'b1, K'(1), 0);

        // start stays high after done: no restart, outputs frozen
        prev_z = z;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b1 || z !== prev_z) bad++;
        end
        check("hold_no_restart", K'(bad), '0);

        a = rand_operand();
        b = rand_operand();
        run_op("pulse_busy", a, b, ref_mulmod(a, b), 60);

        // reset mid-BUSY
        prev_z = z;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        x = rand_operand();
        y = rand_operand();
        start = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("busy z_keeps_old", z, prev_z);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("midrst done", K'(done), '0);
        check("midrst z", z, '0);
        rst = 1'b0;

        a = rand_operand();
        run_op("x_zero", '0, a, '0, 0);
        run_op("y_zero", a, '0, '0, 0);
        run_op("y_one", a, K'(1), a, 0);

        for (int i = 0; i < 6; i++) begin
            a = rand_operand();
            b = rand_operand();
            run_op($sformatf("rand%0d", i), a, b, ref_mulmod(a, b), 0);
        end

`ifdef MOD_MUL_RANGE_CHECK_EN
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        x = M;
        y = K'(1);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("range done", K'(done), K'(1));
        check("range err", K'(err), K'(1));
        check("range z", z, '0);
        a = rand_operand();
        b = rand_operand();
        run_op("range_valid", a, b, ref_mulmod(a, b), 0);
        check("range err_clear", K'(err), '0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mod_mul.md
Name: mod_mul

Overview:
- Sequential k-bit modular multiplier computing z = (x·y) mod m for a fixed compile-time modulus m.
- Uses interleaved (Blakley) shift-add-reduce, MSB of x first, one bit per clock.
- Building block for the RSA/ECC modular-exponentiation datapath. Default modulus is the P-192 prime.

Parameters:
- k, 192: operand/result width in bits.
- logk, 8: bit counter width; must satisfy 2^logk >= k.
- m, 192'hfffffffffffffffffffffffffffffffeffffffffffffffff (2^192-2^64-1): modulus. Requirements: odd is not required; 1 < m < 2^k.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- x  input  k  multiplier operand, MSB-first scanned; requires x < m.
- y  input  k  multiplicand operand; requires y < m.
- start  input  1  level signal; an operation is requested by a 0->1 transition.
- z  output  k  result (x·y) mod m, valid while done=1.
- done  output  1  result-valid flag.

Behaviour:
- Reset:
  - State = IDLE; z=0; done=0; accumulator p=0; counter=0.
  - start_d (previous-cycle start) = 0.
  - Reset mid-operation aborts the operation immediately with the same values.
- Start detection:
  - start_rise = start & ~start_d, sampled every clock.
  - start_rise is accepted only in IDLE or DONE and ignored in BUSY.
  - Holding start high after done does not restart the block.
- States: IDLE, BUSY, DONE.
  - IDLE -> BUSY on an accepted start_rise.
  - BUSY -> DONE when counter=0 and that iteration completes.
  - DONE -> BUSY on start_rise.
  - DONE otherwise holds.
- On acceptance edge E0:
  - Latch x into xr and y into yr; later changes on x/y are ignored.
  - p=0; counter=k-1; done<=0.
- Each BUSY clock, with i=counter:
  - t = 2p + (xr[i] ? yr : 0).
  - If t>=m then t=t-m; repeat once more (t<3m guaranteed).
  - p<=t; counter<=counter-1.
- Internal width: p/t held in k+2 bits to avoid overflow of 2p+y.
- Latency:
  - k BUSY clocks (edges E1..Ek).
  - At Ek: z<=final p, done<=1, state DONE. done is observed high k cycles after the accepting edge.
- z and done hold stable in DONE until the next accepted start or reset. z is not updated in BUSY and keeps its old value.
- Operand range: result equals (x·y) mod m only when x<m and y<m. Out-of-range operands give an unspecified value below 2^k, with no hang.
- Edge cases:
  - x=0 or y=0 -> z=0.
  - y=1 -> z=x.
  - Result always < m.

Optional Feature:
- MOD_MUL_RANGE_CHECK_EN defined:
  - Adds output err (1 bit, reset 0).
  - On an accepted start, if x>=m or y>=m: skip BUSY, go directly to DONE at the next edge with z=0, done=1, err=1.
  - Otherwise err<=0 at acceptance and the normal operation runs.
  - err holds with done.
- Not defined: no err port, no operand comparison. Behaviour is as in Behaviour above.

Test Plan:
- Reset asserted 1 cycle with start=0 -> z=0, done=0. Then start 0->1 with x=0xF7, y=0x0A -> done after exactly k cycles, z=0x9A6.
- x=2^64+1 (0x1_0000000000000001), y=same -> z=0x1_0000000000000002_0000000000000001.
- x=0x1_0000000000000001, y=0xB_000000000000000B -> z=0xB_0000000000000016_000000000000000B.
- Wrap-around:
  - x=2^191, y=2 -> z=0x1_0000000000000001 (2^192 mod m).
  - x=y=m-1 -> z=1.
- Handshake:
  - Keep start high after done -> no restart; done and z stay stable for 100 cycles.
  - Pulse start during BUSY -> ignored, original result delivered.
  - Assert rst mid-BUSY -> done=0, z=0 next cycle.
- With MOD_MUL_RANGE_CHECK_EN: x=m, y=1 -> one cycle later done=1, err=1, z=0. Then a valid operation -> err=0.
